mul_seq_ctrl: RTL and testbench



---
 rtl/mul_seq_ctrl_pkg.sv | 16 +
 rtl/mul_seq_ctrl.sv | 121 ++++++++++++
 tb/tb_mul_seq_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mul_seq_ctrl_pkg.sv
// Shared types for the repeated-addition multiplier sequencing controller.
// The CLR state is only reachable with MUL_SEQ_CTRL_ZERO_BYPASS_EN defined.
package mul_seq_ctrl_pkg;

    localparam int DEF_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        LOOP   = 3'd3,
        DONE   = 3'd4,
        CLR    = 3'd5
    } state_t;

endpackage

// File: rtl/mul_seq_ctrl.sv
// Sequencer for the A/P/B repeated-addition multiplier datapath.
// Optional MUL_SEQ_CTRL_ZERO_BYPASS_EN: zero operands skip straight to DONE via CLR.
module mul_seq_ctrl
    import mul_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             abort,
    input  logic             eqz,
    output logic [WIDTH-1:0] data_in,
    output logic             LdA,
    output logic             LdB,
    output logic             LdP,
    output logic             clrP,
    output logic             decB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] iter_cnt
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cap_a_q, cap_a_d;
    logic [WIDTH-1:0] cap_b_q, cap_b_d;
    logic [WIDTH-1:0] iter_q, iter_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             lda_q, ldb_q, ldp_q, clrp_q, decb_q;
    logic             busy_q, done_q;
    logic             ldp_d;
    logic             zero_op;

`ifdef MUL_SEQ_CTRL_ZERO_BYPASS_EN
    assign zero_op = (op_a == '0) || (op_b == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cap_a_d = cap_a_q;
        cap_b_d = cap_b_q;
        iter_d  = iter_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cap_a_d = op_a;
                    cap_b_d = op_b;
                    iter_d  = '0;
                    state_d = zero_op ? CLR : LOAD_A;
                end
            end
            LOAD_A: state_d = LOAD_B;
            LOAD_B: state_d = LOOP;
            LOOP: begin
                if (ldp_q) iter_d = iter_q + WIDTH'(1);
                if (eqz) state_d = DONE;
            end
`ifdef MUL_SEQ_CTRL_ZERO_BYPASS_EN
            CLR:    state_d = DONE;
`endif
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort && (state_q != IDLE)) state_d = IDLE;
    end

    // Strobes are registered, so the accumulate strobe is predicted from the
    // iteration count; eqz only decides when LOOP is left.
    assign ldp_d = (state_d == LOOP) && (iter_d != cap_b_d);

    always_comb begin
        data_d = '0;
        if (state_d == LOAD_A) data_d = cap_a_d;
        if (state_d == LOAD_B) data_d = cap_b_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cap_a_q <= '0;
            cap_b_q <= '0;
            iter_q  <= '0;
            data_q  <= '0;
            lda_q   <= 1'b0;
            ldb_q   <= 1'b0;
            ldp_q   <= 1'b0;
            clrp_q  <= 1'b0;
            decb_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cap_a_q <= cap_a_d;
            cap_b_q <= cap_b_d;
            iter_q  <= iter_d;
            data_q  <= data_d;
            lda_q   <= (state_d == LOAD_A);
            ldb_q   <= (state_d == LOAD_B);
            ldp_q   <= ldp_d;
            clrp_q  <= (state_d == LOAD_A) || (state_d == CLR);
            decb_q  <= ldp_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    assign data_in  = data_q;
    assign LdA      = lda_q;
    assign LdB      = ldb_q;
    assign LdP      = ldp_q;
    assign clrP     = clrp_q;
    assign decB     = decb_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign iter_cnt = iter_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl driving a behavioural A/B/P datapath.
// Expectations follow MUL_SEQ_CTRL_ZERO_BYPASS_EN when it is defined.
module tb_mul_seq_ctrl;

    localparam int W = 16;
`ifdef MUL_SEQ_CTRL_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         abort = 1'b0;
    logic         eqz;
    logic [W-1:0] data_in;
    logic         LdA, LdB, LdP, clrP, decB, busy, done;
    logic [W-1:0] iter_cnt;

    logic [W-1:0] reg_a, reg_b, reg_p;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mul_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
        .abort(abort), .eqz(eqz), .data_in(data_in), .LdA(LdA), .LdB(LdB),
        .LdP(LdP), .clrP(clrP), .decB(decB), .busy(busy), .done(done),
        .iter_cnt(iter_cnt)
    );

    // Behavioural datapath
    assign eqz = (reg_b == '0);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_a <= '0;
            reg_b <= '0;
            reg_p <= '0;
        end else begin
            if (LdA) reg_a <= data_in;
            if (LdB) reg_b <= data_in;
            else if (decB) reg_b <= reg_b - 1'b1;
            if (clrP) reg_p <= '0;
            else if (LdP) reg_p <= reg_p + reg_a;
        end
    end

    function automatic logic [6:0] vec();
        return {LdA, LdB, LdP, clrP, decB, busy, done};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and check every cycle until back in IDLE.
    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b);
        bit byp;
        int last;
        logic [6:0] ev;
        logic [W-1:0] ed;
        logic [W-1:0] prod;
        byp  = BYP && (a == '0 || b == '0);
        last = byp ? 2 : int'(b) + 4;
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        step();
        start = 1'b0;
        op_a  = ~a;
        op_b  = b + 16'd3;
        for (int c = 1; c <= last + 1; c++) begin
            if (byp) begin
                ev = {1'b0, 1'b0, 1'b0, c == 1, 1'b0, c <= 2, c == 2};
                ed = '0;
            end else begin
                ev = {c == 1, c == 2, c >= 3 && c <= int'(b) + 2, c == 1,
                      c >= 3 && c <= int'(b) + 2, c <= last, c == last};
                ed = (c == 1) ? a : (c == 2) ? b : '0;
            end
            chk($sformatf("strobes a=%0h b=%0d c=%0d", a, b, c), 32'(vec()), 32'(ev));
            chk($sformatf("data_in a=%0h b=%0d c=%0d", a, b, c), 32'(data_in), 32'(ed));
            if (c <= last) step();
        end
        prod = W'(32'(a) * 32'(b));
        chk($sformatf("iter_cnt a=%0h b=%0d", a, b), 32'(iter_cnt),
            byp ? 32'd0 : 32'(b));
        chk($sformatf("product a=%0h b=%0d", a, b), 32'(reg_p), 32'(prod));
    endtask

    initial begin
        #12;
        chk("reset strobes", 32'(vec()), 32'd0);
        chk("reset data_in", 32'(data_in), 32'd0);
        chk("reset iter_cnt", 32'(iter_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Asynchronous reset during LOOP
        start = 1'b1;
        op_a  = 16'd3;
        op_b  = 16'd9;
        step();
        start = 1'b0;
        step();
        step();
        step();
        step();
        chk("mid-loop LdP", 32'(LdP), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async rst strobes", 32'(vec()), 32'd0);
        chk("async rst data_in", 32'(data_in), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        run(16'd7, 16'd5);
        run(16'd9, 16'd0);
        run(16'hFFFF, 16'd2);
        run(16'd0, 16'd3);

        // Start while busy is ignored; abort in cycle 4 returns to IDLE
        start = 1'b1;
        op_a  = 16'd4;
        op_b  = 16'd6;
        step();
        op_a = 16'd11;
        op_b = 16'd2;
        step();
        chk("busy start data_in", 32'(data_in), 32'd6);
        step();
        start = 1'b0;
        step();
        chk("pre-abort LdP", 32'(vec()), 32'b0010110);
        abort = 1'b1;
        step();
        abort = 1'b0;
        for (int c = 5; c <= 8; c++) begin
            chk($sformatf("post-abort c=%0d", c), 32'(vec()), 32'd0);
            step();
        end

        // Start held high: back-to-back operations
        start = 1'b1;
        op_a  = 16'd2;
        op_b  = 16'd1;
        step();
        for (int c = 1; c <= 12; c++) begin
            chk($sformatf("held busy/done c=%0d", c), 32'({busy, done}),
                32'({!(c == 6 || c == 12), c == 5 || c == 11}));
            if (c == 12) start = 1'b0;
            step();
        end
        chk("held idle", 32'(busy), 32'd0);
        chk("held product", 32'(reg_p), 32'd2);
        chk("held iter_cnt", 32'(iter_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
